// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
// Control-and-receive end of a shared tri-state bus.
// Accepts (source, destination) transfer requests and enables exactly one
// source driver at a time. The resolved bus is sampled after one settle
// cycle into a bank of destination registers. A turnaround cycle with all
// enables low is inserted before the next transfer can start.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  transfer request present
//   req_src    index of the driver to enable
//   req_dst    index of the destination register
//   req_ready  controller can accept a request (IDLE)
//   src_en     registered one-hot-or-zero driver enables
//   bus_in     resolved shared bus value
//   rd_sel     destination register read select
//   rd_data    combinational read of dst_reg[rd_sel]; 0 when out of range
//   done       one-cycle pulse after the destination register is written
//   err        one-cycle pulse after a request with an out-of-range index
module bus_xfer_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned NUM_DST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [$clog2(NUM_SRC)-1:0] req_src,
  input  logic [$clog2(NUM_DST)-1:0] req_dst,
  output logic                       req_ready,
  output logic [NUM_SRC-1:0]         src_en,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic [$clog2(NUM_DST)-1:0] rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned SW = $clog2(NUM_SRC);
  localparam int unsigned DW = $clog2(NUM_DST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      sel_src_q, sel_src_d;
  logic [DW-1:0]      sel_dst_q, sel_dst_d;
  logic [NUM_SRC-1:0] src_en_q, src_en_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   dst_q [NUM_DST];

  logic               src_ok;
  logic               dst_ok;
  logic [NUM_SRC-1:0] req_onehot;

  // Index range checks matter only when NUM_SRC/NUM_DST are not powers of two.
  assign src_ok = (32'(req_src) < NUM_SRC);
  assign dst_ok = (32'(req_dst) < NUM_DST);

  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req_src == SW'(i)) req_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_src_d = sel_src_q;
    sel_dst_d = sel_dst_q;
    src_en_d  = src_en_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        src_en_d = '0;
        if (req_valid) begin
          sel_src_d = req_src;
          sel_dst_d = req_dst;
          if (src_ok && dst_ok) begin
            state_d  = DRIVE;
            src_en_d = req_onehot;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: state_d = LATCH;
      LATCH: begin
        src_en_d = '0;
        state_d  = GAP;
      end
      GAP: begin
        src_en_d = '0;
        state_d  = IDLE;
      end
      default: begin
        src_en_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_src_q <= '0;
      sel_dst_q <= '0;
      src_en_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_src_q <= sel_src_d;
      sel_dst_q <= sel_dst_d;
      src_en_q  <= src_en_d;
      err_q     <= err_d;
    end
  end

  // The bus is captured at the end of LATCH, after a full settle cycle in DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DST; i++) dst_q[i] <= '0;
    end else if (state_q == LATCH) begin
      for (int unsigned i = 0; i < NUM_DST; i++) begin
        if (sel_dst_q == DW'(i)) dst_q[i] <= bus_in;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_DST; i++) begin
      if (rd_sel == DW'(i)) rd_data = dst_q[i];
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == GAP);
  assign err       = err_q;
  assign src_en    = src_en_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

  logic       clk;
  logic       rst_n;

  logic       a_req_valid;
  logic [1:0] a_req_src;
  logic [1:0] a_req_dst;
  logic       a_req_ready;
  logic [3:0] a_src_en;
  logic [3:0] a_bus_in;
  logic [1:0] a_rd_sel;
  logic [3:0] a_rd_data;
  logic       a_done;
  logic       a_err;

  logic       b_req_valid;
  logic [1:0] b_req_src;
  logic [1:0] b_req_dst;
  logic       b_req_ready;
  logic [2:0] b_src_en;
  logic [3:0] b_bus_in;
  logic [1:0] b_rd_sel;
  logic [3:0] b_rd_data;
  logic       b_done;
  logic       b_err;

  int n_assert;
  int n_fail;

  bus_xfer_ctrl #(.WIDTH(4), .NUM_SRC(4), .NUM_DST(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_src   (a_req_src),
    .req_dst   (a_req_dst),
    .req_ready (a_req_ready),
    .src_en    (a_src_en),
    .bus_in    (a_bus_in),
    .rd_sel    (a_rd_sel),
    .rd_data   (a_rd_data),
    .done      (a_done),
    .err       (a_err)
  );

  bus_xfer_ctrl #(.WIDTH(4), .NUM_SRC(3), .NUM_DST(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_src   (b_req_src),
    .req_dst   (b_req_dst),
    .req_ready (b_req_ready),
    .src_en    (b_src_en),
    .bus_in    (b_bus_in),
    .rd_sel    (b_rd_sel),
    .rd_data   (b_rd_data),
    .done      (b_done),
    .err       (b_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    a_rd_sel = sel;
    #1;
    chk(tag, 32'(a_rd_data), 32'(exp));
  endtask

  task automatic rd_b(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    b_rd_sel = sel;
    #1;
    chk(tag, 32'(b_rd_data), 32'(exp));
  endtask

  // Bus invariants checked every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_onehot0", 32'($onehot0(a_src_en)), 32'd1);
      chk("b_onehot0", 32'($onehot0(b_src_en)), 32'd1);
      chk("a_done_err_excl", 32'(a_done & a_err), 32'd0);
      chk("b_done_err_excl", 32'(b_done & b_err), 32'd0);
    end
  end

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    a_req_valid = 1'b0;
    a_req_src   = '0;
    a_req_dst   = '0;
    a_bus_in    = '0;
    a_rd_sel    = '0;
    b_req_valid = 1'b0;
    b_req_src   = '0;
    b_req_dst   = '0;
    b_bus_in    = '0;
    b_rd_sel    = '0;

    // Reset state
    #1;
    chk("rst_src_en", 32'(a_src_en), 32'h0);
    chk("rst_ready", 32'(a_req_ready), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rd_a("rst_dst0", 2'd0, 4'h0);
    rd_a("rst_dst1", 2'd1, 4'h0);
    rd_a("rst_dst2", 2'd2, 4'h0);
    rd_a("rst_dst3", 2'd3, 4'h0);

    // Single transfer src=2 -> dst=1, bus=A
    a_req_valid = 1'b1;
    a_req_src   = 2'd2;
    a_req_dst   = 2'd1;
    a_bus_in    = 4'hA;
    tick();                                  // E0
    a_req_valid = 1'b0;
    chk("t1_drive_en", 32'(a_src_en), 32'h4);
    chk("t1_drive_ready", 32'(a_req_ready), 32'd0);
    chk("t1_drive_done", 32'(a_done), 32'd0);
    tick();                                  // E1
    chk("t1_latch_en", 32'(a_src_en), 32'h4);
    chk("t1_latch_done", 32'(a_done), 32'd0);
    tick();                                  // E2
    chk("t1_gap_en", 32'(a_src_en), 32'h0);
    chk("t1_gap_done", 32'(a_done), 32'd1);
    chk("t1_gap_ready", 32'(a_req_ready), 32'd0);
    rd_a("t1_rd_dst1", 2'd1, 4'hA);
    tick();                                  // E3
    chk("t1_idle_done", 32'(a_done), 32'd0);
    chk("t1_idle_ready", 32'(a_req_ready), 32'd1);
    rd_a("t1_dst0", 2'd0, 4'h0);
    rd_a("t1_dst2", 2'd2, 4'h0);
    rd_a("t1_dst3", 2'd3, 4'h0);

    // Back-to-back: (0->0, bus 3) then (3->3, bus C), req_valid held high
    a_req_valid = 1'b1;
    a_req_src   = 2'd0;
    a_req_dst   = 2'd0;
    a_bus_in    = 4'h3;
    tick();                                  // accept #1
    chk("b2b_1_drive", 32'(a_src_en), 32'h1);
    tick();
    chk("b2b_1_latch", 32'(a_src_en), 32'h1);
    a_req_src = 2'd3;
    a_req_dst = 2'd3;
    tick();
    chk("b2b_gap_en", 32'(a_src_en), 32'h0);
    chk("b2b_gap_done", 32'(a_done), 32'd1);
    a_bus_in = 4'hC;
    tick();
    chk("b2b_idle_en", 32'(a_src_en), 32'h0);
    chk("b2b_idle_ready", 32'(a_req_ready), 32'd1);
    tick();                                  // accept #2, 4 cycles after #1
    chk("b2b_2_drive", 32'(a_src_en), 32'h8);
    chk("b2b_2_ready", 32'(a_req_ready), 32'd0);
    a_req_valid = 1'b0;
    tick();
    chk("b2b_2_latch", 32'(a_src_en), 32'h8);
    tick();
    chk("b2b_2_done", 32'(a_done), 32'd1);
    tick();
    rd_a("b2b_dst0", 2'd0, 4'h3);
    rd_a("b2b_dst3", 2'd3, 4'hC);
    rd_a("b2b_dst1", 2'd1, 4'hA);
    rd_a("b2b_dst2", 2'd2, 4'h0);

    // Index change during DRIVE; also first write of the overwrite pair
    a_req_valid = 1'b1;
    a_req_src   = 2'd1;
    a_req_dst   = 2'd2;
    a_bus_in    = 4'h5;
    tick();
    a_req_src = 2'd3;
    a_req_dst = 2'd0;
    chk("chg_drive_en", 32'(a_src_en), 32'h2);
    tick();
    a_req_valid = 1'b0;
    chk("chg_latch_en", 32'(a_src_en), 32'h2);
    tick();
    chk("chg_done", 32'(a_done), 32'd1);
    rd_a("ovw_dst2_first", 2'd2, 4'h5);
    rd_a("chg_dst0_kept", 2'd0, 4'h3);
    tick();

    // Overwrite dst2 with 9
    a_req_valid = 1'b1;
    a_req_src   = 2'd0;
    a_req_dst   = 2'd2;
    a_bus_in    = 4'h9;
    tick();
    a_req_valid = 1'b0;
    tick();
    tick();
    chk("ovw_done", 32'(a_done), 32'd1);
    rd_a("ovw_dst2_second", 2'd2, 4'h9);
    tick();
    rd_a("ovw_dst0", 2'd0, 4'h3);
    rd_a("ovw_dst1", 2'd1, 4'hA);
    rd_a("ovw_dst3", 2'd3, 4'hC);

    // Out-of-range source on the 3-driver instance
    b_req_valid = 1'b1;
    b_req_src   = 2'd3;
    b_req_dst   = 2'd0;
    b_bus_in    = 4'h7;
    tick();
    b_req_valid = 1'b0;
    chk("err_pulse", 32'(b_err), 32'd1);
    chk("err_ready", 32'(b_req_ready), 32'd1);
    chk("err_src_en", 32'(b_src_en), 32'h0);
    tick();
    chk("err_clear", 32'(b_err), 32'd0);
    chk("err_src_en2", 32'(b_src_en), 32'h0);
    chk("err_no_done", 32'(b_done), 32'd0);
    tick();
    chk("err_src_en3", 32'(b_src_en), 32'h0);
    rd_b("err_dst0", 2'd0, 4'h0);
    rd_b("err_dst3", 2'd3, 4'h0);

    // Reset during LATCH of a transfer writing F
    a_req_valid = 1'b1;
    a_req_src   = 2'd3;
    a_req_dst   = 2'd1;
    a_bus_in    = 4'hF;
    tick();
    a_req_valid = 1'b0;
    tick();
    chk("rstm_latch_en", 32'(a_src_en), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_async_en", 32'(a_src_en), 32'h0);
    chk("rstm_ready", 32'(a_req_ready), 32'd1);
    chk("rstm_done", 32'(a_done), 32'd0);
    tick();
    chk("rstm_done_held", 32'(a_done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rstm_no_done", 32'(a_done), 32'd0);
    chk("rstm_idle_ready", 32'(a_req_ready), 32'd1);
    rd_a("rstm_dst1", 2'd1, 4'h0);
    rd_a("rstm_dst3", 2'd3, 4'h0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
